// File: rtl/counter_timer_ctrl_pkg.sv
// Shared types and helpers for the modulo-N counter/timer controller.
// A programmed period of zero stands for the full 2**N count range.
package counter_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctl_state_t;

    localparam int unsigned PERIOD_ZERO_CODE = 32'd0;

    // Number of counts per period; the zero code expands to 2**n.
    function automatic int unsigned period_counts(input int unsigned period,
                                                  input int unsigned n);
        if (period == PERIOD_ZERO_CODE) begin
            return 32'd1 << n;
        end else begin
            return period;
        end
    endfunction

endpackage

// File: rtl/counter_timer_ctrl_if.sv
// Config/command/status bundle between a host and counter_timer_ctrl.
// master drives config and commands; slave is the controller.
interface counter_timer_ctrl_if #(parameter int unsigned N = 4);

    logic         cfg_valid;
    logic         cfg_ready;
    logic [N-1:0] cfg_period;
    logic         cfg_periodic;
    logic         start;
    logic         pause;
    logic         stop;
    logic         busy;
    logic [N-1:0] cnt;
    logic         tick;
    logic         done;

    modport master (
        output cfg_valid, cfg_period, cfg_periodic, start, pause, stop,
        input  cfg_ready, busy, cnt, tick, done
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_periodic, start, pause, stop,
        output cfg_ready, busy, cnt, tick, done
    );

endinterface

// File: rtl/counter_timer_ctrl_mod_counter.sv
// Modulo counter datapath: wraps to zero after reaching tc.
// clear has priority over en; at_tc flags the terminal value.
module mod_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [N-1:0] tc,
    output logic [N-1:0] cnt,
    output logic         at_tc
);

    logic [N-1:0] cnt_r;

    assign cnt   = cnt_r;
    assign at_tc = (cnt_r == tc);

    // Count register: clear, then wrap at tc, else increment when enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == tc) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + N'(1);
            end
        end
    end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Sequencing controller for a modulo-N up-counter: holds period/mode,
// runs/pauses/stops the datapath and emits registered tick/done pulses.
module counter_timer_ctrl
    import counter_timer_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned DEFAULT_PERIOD = 9
) (
    input  logic                clock,
    input  logic                reset,
    counter_timer_ctrl_if.slave bus
);

    ctl_state_t   state_r;
    logic [N-1:0] period_r;
    logic         periodic_r;
    logic         tick_r;
    logic         done_r;

    logic [N-1:0] tc_s;
    logic         at_tc_s;
    logic         clear_s;
    logic         en_s;
    logic [N-1:0] cnt_s;

    // Period 0 yields TC of all ones through N-bit truncation of 2**N - 1.
    assign tc_s = N'(period_counts(32'(period_r), N) - 32'd1);

    // IDLE holds the count at zero; a resumed HOLD counts on its release edge.
    assign clear_s = bus.stop || (state_r == IDLE);
    assign en_s    = (state_r != IDLE) &&
                     (!bus.pause || ((state_r == RUN) && at_tc_s));

    mod_counter #(.N(N)) u_counter (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .en    (en_s),
        .tc    (tc_s),
        .cnt   (cnt_s),
        .at_tc (at_tc_s)
    );

    assign bus.cnt       = cnt_s;
    assign bus.tick      = tick_r;
    assign bus.done      = done_r;
    assign bus.busy      = (state_r != IDLE);
    assign bus.cfg_ready = (state_r == IDLE);

    // Controller FSM, config registers and pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            period_r   <= N'(DEFAULT_PERIOD);
            periodic_r <= 1'b0;
            tick_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;

            if ((state_r == IDLE) && bus.cfg_valid) begin
                period_r   <= bus.cfg_period;
                periodic_r <= bus.cfg_periodic;
            end

            if (bus.stop) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.start) begin
                            state_r <= RUN;
                        end
                    end
                    RUN, HOLD: begin
                        if ((state_r == HOLD) && bus.pause) begin
                            state_r <= HOLD;
                        end else if (at_tc_s) begin
                            // The wrap always completes before a pause takes effect.
                            tick_r <= 1'b1;
                            if (!periodic_r) begin
                                state_r <= IDLE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= bus.pause ? HOLD : RUN;
                            end
                        end else begin
                            state_r <= bus.pause ? HOLD : RUN;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed self-checking bench for counter_timer_ctrl (N=4, DEFAULT_PERIOD=9).
// Inputs change 10 time units after each rising edge; outputs are checked there.
module tb_counter_timer_ctrl;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    counter_timer_ctrl_if #(.N(4)) bus ();

    counter_timer_ctrl #(.N(4), .DEFAULT_PERIOD(9)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #10;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input int c, input int t, input int d, input int b);
        chk({tag, ".cnt"},  int'(bus.cnt),  c);
        chk({tag, ".tick"}, int'(bus.tick), t);
        chk({tag, ".done"}, int'(bus.done), d);
        chk({tag, ".busy"}, int'(bus.busy), b);
    endtask

    task automatic config_and_start(input logic [3:0] period, input logic periodic);
        bus.cfg_valid    = 1'b1;
        bus.cfg_period   = period;
        bus.cfg_periodic = periodic;
        bus.start        = 1'b1;
        cycle();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        bus.cfg_valid    = 1'b0;
        bus.cfg_period   = 4'd0;
        bus.cfg_periodic = 1'b0;
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        bus.stop         = 1'b0;
        cycle();
        cycle();
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.cfg_ready", int'(bus.cfg_ready), 1);
        reset = 1'b0;

        // 1: default period 9, one-shot
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk_out("t1.start", 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk_out("t1.count", i, 0, 0, 1);
        end
        cycle();
        chk_out("t1.wrap", 0, 1, 1, 0);
        cycle();
        chk_out("t1.after", 0, 0, 0, 0);

        // 2: period 3 periodic, configured one cycle before start
        bus.cfg_valid    = 1'b1;
        bus.cfg_period   = 4'd3;
        bus.cfg_periodic = 1'b1;
        cycle();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk_out("t2.start", 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            chk_out("t2.count", k % 3, (k % 3 == 0) ? 1 : 0, 0, 1);
        end
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk_out("t2.stop", 0, 0, 0, 0);

        // 3: period 5 periodic, pause at cnt=1 for 4 cycles
        config_and_start(4'd5, 1'b1);
        chk_out("t3.start", 0, 0, 0, 1);
        cycle();
        chk_out("t3.c1", 1, 0, 0, 1);
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk_out("t3.hold", 1, 0, 0, 1);
        end
        bus.pause = 1'b0;
        cycle();
        chk_out("t3.resume", 2, 0, 0, 1);
        cycle();
        chk_out("t3.c3", 3, 0, 0, 1);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk_out("t3.start_ignored", 4, 0, 0, 1);
        bus.pause = 1'b1;
        cycle();
        chk_out("t3.pause_at_tc", 0, 1, 0, 1);
        cycle();
        chk_out("t3.hold0", 0, 0, 0, 1);
        bus.pause = 1'b0;
        bus.stop  = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk_out("t3.stop", 0, 0, 0, 0);

        // 4: stop coinciding with terminal count, one-shot period 3
        config_and_start(4'd3, 1'b0);
        cycle();
        cycle();
        chk_out("t4.at_tc", 2, 0, 0, 1);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk_out("t4.stop_tc", 0, 0, 0, 0);
        cycle();
        chk_out("t4.after", 0, 0, 0, 0);

        // 5a: period 0 means 16 counts per tick
        config_and_start(4'd0, 1'b1);
        chk_out("t5.start", 0, 0, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            cycle();
            chk_out("t5.count16", i, 0, 0, 1);
        end
        cycle();
        chk_out("t5.wrap16", 0, 1, 0, 1);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;

        // 5b: period 1 ticks every cycle with cnt stuck at 0
        config_and_start(4'd1, 1'b1);
        chk_out("t5.p1start", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_out("t5.p1tick", 0, 1, 0, 1);
        end
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk_out("t5.p1stop", 0, 0, 0, 0);

        // 6: config held during a one-shot period-4 run waits for IDLE
        config_and_start(4'd4, 1'b0);
        bus.cfg_valid    = 1'b1;
        bus.cfg_period   = 4'd7;
        bus.cfg_periodic = 1'b1;
        chk("t6.cfg_ready_run", int'(bus.cfg_ready), 0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk_out("t6.oldcfg", i, 0, 0, 1);
            chk("t6.cfg_ready", int'(bus.cfg_ready), 0);
        end
        cycle();
        chk_out("t6.olddone", 0, 1, 1, 0);
        chk("t6.cfg_ready_idle", int'(bus.cfg_ready), 1);
        cycle();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
        end
        chk_out("t6.newcfg6", 6, 0, 0, 1);
        cycle();
        chk_out("t6.newwrap", 0, 1, 0, 1);
        cycle();
        chk_out("t6.c1", 1, 0, 0, 1);

        // reset mid-run restores all defaults
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk_out("t6.reset", 0, 0, 0, 0);
        chk("t6.reset_cfg_ready", int'(bus.cfg_ready), 1);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
        end
        chk_out("t6.default8", 8, 0, 0, 1);
        cycle();
        chk_out("t6.defaultdone", 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
